// File: rtl/dct_muladd_pipe.sv
// Lane-parallel fixed-point multiply, pipelined adder tree and beat accumulator
// with saturation; a single stall signal freezes every stage under backpressure.
module dct_muladd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int DATA_DEPTH = 8,
  parameter int ACC_BEATS  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] coeff,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_sat
);

  localparam int W   = DATA_WIDTH;
  localparam int LVL = $clog2(DATA_DEPTH);
  localparam int TW  = W + LVL;
  localparam int AW  = W + LVL + 7;
  localparam int PW  = 2 * W;
  localparam int CW  = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;

  localparam logic signed [W-1:0]  W_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  W_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0] P_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [TW-1:0] T_MAX = {{(LVL+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [TW-1:0] T_MIN = {{(LVL+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] A_MAX = {{(LVL+8){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] A_MIN = {{(LVL+8){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0] RND   = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  // Level 0 holds the registered lane products; level l holds DATA_DEPTH>>l tree nodes.
  logic signed [TW-1:0] t_q [LVL+1][DATA_DEPTH];
  logic signed [TW-1:0] t_d [LVL+1][DATA_DEPTH];
  logic                 t_ovf [LVL+1];
  logic                 v_q [LVL+1];
  logic                 s_q [LVL+1];

  logic signed [TW-1:0] m_d [DATA_DEPTH];
  logic                 m_ovf;
  logic signed [PW-1:0] prod, shifted;
  logic signed [W-1:0]  lane_w;

  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] acc_q, acc_base, acc_next;
  logic                 acc_sat, acc_done;
  logic                 first_beat, last_beat;
  logic [W-1:0]         fin_data;
  logic                 fin_clamp;

  assign in_ready = !(out_valid && !out_ready);

  always_comb begin
    m_ovf   = 1'b0;
    prod    = '0;
    shifted = '0;
    lane_w  = '0;
    for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
      prod    = $signed(data_in[i*W +: W]) * $signed(coeff[i*W +: W]);
      shifted = (prod + RND) >>> FRAC_BITS;
      if (shifted > P_MAX) begin
        lane_w = W_MAX;
        m_ovf  = 1'b1;
      end else if (shifted < P_MIN) begin
        lane_w = W_MIN;
        m_ovf  = 1'b1;
      end else begin
        lane_w = shifted[W-1:0];
      end
      m_d[i] = {{LVL{lane_w[W-1]}}, lane_w};
    end
  end

  // Nodes are carried at the full tree width so no level ever truncates.
  always_comb begin
    for (int unsigned l = 0; l <= LVL; l++) begin
      t_ovf[l] = 1'b0;
      for (int unsigned n = 0; n < DATA_DEPTH; n++) t_d[l][n] = '0;
    end
    for (int unsigned l = 1; l <= LVL; l++) begin
      for (int unsigned n = 0; n < (DATA_DEPTH >> l); n++) begin
        t_d[l][n] = t_q[l-1][2*n] + t_q[l-1][2*n+1];
        if (t_d[l][n] > T_MAX || t_d[l][n] < T_MIN) t_ovf[l] = 1'b1;
      end
    end
  end

  always_comb begin
    first_beat = (cnt == '0);
    last_beat  = (cnt == CW'(ACC_BEATS - 1));
    acc_base   = first_beat ? '0 : acc_q;
    acc_next   = acc_base + {{(AW-TW){t_q[LVL][0][TW-1]}}, t_q[LVL][0]};
    fin_clamp  = 1'b0;
    if (acc_q > A_MAX) begin
      fin_data  = W_MAX;
      fin_clamp = 1'b1;
    end else if (acc_q < A_MIN) begin
      fin_data  = W_MIN;
      fin_clamp = 1'b1;
    end else begin
      fin_data  = acc_q[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned l = 0; l <= LVL; l++) begin
        v_q[l] <= 1'b0;
        s_q[l] <= 1'b0;
        for (int unsigned n = 0; n < DATA_DEPTH; n++) t_q[l][n] <= '0;
      end
      cnt       <= '0;
      acc_q     <= '0;
      acc_sat   <= 1'b0;
      acc_done  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (in_ready) begin
      v_q[0] <= in_valid;
      s_q[0] <= m_ovf;
      t_q[0] <= m_d;
      for (int unsigned l = 1; l <= LVL; l++) begin
        v_q[l] <= v_q[l-1];
        s_q[l] <= s_q[l-1] | t_ovf[l];
        t_q[l] <= t_d[l];
      end
      acc_done <= 1'b0;
      if (v_q[LVL]) begin
        acc_q    <= acc_next;
        acc_sat  <= (first_beat ? 1'b0 : acc_sat) | s_q[LVL];
        acc_done <= last_beat;
        cnt      <= last_beat ? '0 : cnt + 1'b1;
      end
      out_valid <= acc_done;
      if (acc_done) begin
        out_data <= fin_data;
        out_sat  <= acc_sat | fin_clamp;
      end
    end
  end

endmodule

// File: tb/tb_dct_muladd_pipe.sv
// Directed bench for dct_muladd_pipe: an arithmetic scoreboard checks every result
// handshake and hold cycle, with literal expectations pinning the directed vectors.
module tb_dct_muladd_pipe;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int BW = W * D;
  localparam longint LMAX = 2147483647;
  localparam longint LMIN = -LMAX - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic iv0, ir0, ov0, or0, os0, iv1, ir1, ov1, or1, os1;
  logic [BW-1:0] d0, c0, d1, c1;
  logic [W-1:0]  od0, od1;

  int compares = 0;
  int fails    = 0;

  dct_muladd_pipe #(.DATA_WIDTH(32), .FRAC_BITS(16), .DATA_DEPTH(8), .ACC_BEATS(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .data_in(d0), .coeff(c0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_sat(os0));

  dct_muladd_pipe #(.DATA_WIDTH(32), .FRAC_BITS(16), .DATA_DEPTH(8), .ACC_BEATS(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .data_in(d1), .coeff(c1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sat(os1));

  longint     g_acc [2];
  int         g_cnt [2];
  bit         g_sat [2];
  bit         held  [2];
  logic [W-1:0] h_data [2];
  logic       h_sat [2];
  int         group_len [2] = '{1, 8};
  logic [W:0] q0 [$];
  logic [W:0] q1 [$];

  // Reference arithmetic: rounded Q16.16 lane products, pairwise sums, range tracking.
  function automatic void beat_eval(input logic [BW-1:0] d, input logic [BW-1:0] c,
                                    output longint sum, output bit sat);
    longint v [D];
    logic signed [W-1:0] a, b;
    longint p;
    sat = 1'b0;
    for (int i = 0; i < D; i++) begin
      a = d[i*W +: W];
      b = c[i*W +: W];
      p = (longint'(a) * longint'(b) + 64'sd32768) >>> 16;
      if (p > LMAX) begin p = LMAX; sat = 1'b1; end
      else if (p < LMIN) begin p = LMIN; sat = 1'b1; end
      v[i] = p;
    end
    for (int n = D / 2; n >= 1; n = n / 2) begin
      for (int j = 0; j < n; j++) begin
        v[j] = v[2*j] + v[2*j+1];
        if (v[j] > LMAX || v[j] < LMIN) sat = 1'b1;
      end
    end
    sum = v[0];
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [W:0] qpop(input int id);
    if (id == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void qpush(input int id, input logic [W:0] e);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic mon(input int id, input logic iv, input logic ir, input logic ov, input logic ordy,
                     input logic [BW-1:0] d, input logic [BW-1:0] c,
                     input logic [W-1:0] od, input logic os);
    logic [W:0]   e;
    logic [W-1:0] rd;
    longint       s;
    bit           bs;
    if (reset) begin
      g_acc[id] = 0; g_cnt[id] = 0; g_sat[id] = 1'b0; held[id] = 1'b0;
      if (id == 0) q0.delete(); else q1.delete();
      return;
    end
    compares++;
    if (ir !== !(ov && !ordy)) begin
      fails++;
      $display("FAIL in_ready_rule dut%0d: got %b want %b", id, ir, !(ov && !ordy));
    end
    if (held[id]) begin
      compares++;
      if (ov !== 1'b1 || od !== h_data[id] || os !== h_sat[id]) begin
        fails++;
        $display("FAIL hold_stable dut%0d: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 id, ov, od, os, h_data[id], h_sat[id]);
      end
    end
    held[id]   = ov && !ordy;
    h_data[id] = od;
    h_sat[id]  = os;
    if (ov && ordy) begin
      compares++;
      if (qsize(id) == 0) begin
        fails++;
        $display("FAIL unexpected_result dut%0d: got d=%h s=%b want no result", id, od, os);
      end else begin
        e = qpop(id);
        if ({os, od} !== e) begin
          fails++;
          $display("FAIL result dut%0d: got d=%h s=%b want d=%h s=%b", id, od, os, e[W-1:0], e[W]);
        end
      end
    end
    if (iv && ir) begin
      beat_eval(d, c, s, bs);
      g_acc[id] += s;
      g_sat[id] |= bs;
      g_cnt[id]++;
      if (g_cnt[id] == group_len[id]) begin
        if (g_acc[id] > LMAX) begin rd = 32'h7FFFFFFF; g_sat[id] = 1'b1; end
        else if (g_acc[id] < LMIN) begin rd = 32'h80000000; g_sat[id] = 1'b1; end
        else rd = g_acc[id][W-1:0];
        qpush(id, {g_sat[id], rd});
        g_acc[id] = 0; g_cnt[id] = 0; g_sat[id] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, iv0, ir0, ov0, or0, d0, c0, od0, os0);
    mon(1, iv1, ir1, ov1, or1, d1, c1, od1, os1);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    compares++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, input logic [BW-1:0] d, input logic [BW-1:0] c);
    if (id == 0) begin iv0 = v; d0 = d; c0 = c; end
    else begin iv1 = v; d1 = d; c1 = c; end
  endtask

  task automatic send(input int id, input logic [BW-1:0] d, input logic [BW-1:0] c);
    logic took;
    drive(id, 1'b1, d, c);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      took = (id == 0) ? ir0 : ir1;
      tick();
      if (took) return;
    end
    compares++;
    fails++;
    $display("FAIL send_timeout dut%0d: in_ready 0 for 100 cycles, want 1", id);
  endtask

  task automatic beat(input int id, input logic [BW-1:0] d, input logic [BW-1:0] c);
    send(id, d, c);
    drive(id, 1'b0, d, c);
  endtask

  task automatic expect_lit(input int id, input logic [W-1:0] ed, input logic es, input string nm);
    logic hs;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hs = (id == 0) ? (ov0 && or0) : (ov1 && or1);
      if (hs) begin
        chk(nm, (id == 0) ? {os0, od0} : {os1, od1}, {es, ed});
        tick();
        return;
      end
    end
    compares++;
    fails++;
    $display("FAIL %s: got no result in 40 cycles want d=%h s=%b", nm, ed, es);
    tick();
  endtask

  function automatic logic [BW-1:0] one(input int i, input logic [W-1:0] v);
    logic [BW-1:0] r;
    r = '0;
    r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_bus(input int mag);
    logic [BW-1:0] r;
    int x;
    for (int i = 0; i < D; i++) begin
      x = int'($urandom_range(0, 2 * mag - 1)) - mag;
      r[i*W +: W] = x;
    end
    return r;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, first, last;
    logic got;
    reset = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    or0 = 1'b1;
    or1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid0", ov0, 0);
    chk("reset_out_data0", od0, 0);
    chk("reset_out_sat0", os0, 0);
    chk("reset_in_ready0", ir0, 1);
    chk("reset_out_valid1", ov1, 0);
    chk("reset_in_ready1", ir1, 1);
    tick();

    send(0, {D{32'h00010000}}, {D{32'h00008000}});
    drive(0, 1'b0, '0, '0);
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      tick();
      n++;
      got = ov0;
    end
    chk("latency", n, 5);
    chk("basic_data", od0, 32'h00040000);
    chk("basic_sat", os0, 0);
    tick();
    tick();

    beat(0, one(0, 32'h00000001), one(0, 32'h00008000));
    expect_lit(0, 32'h00000001, 1'b0, "round_half_up");
    beat(0, one(0, 32'hFFFFFFFF), one(0, 32'h00008000));
    expect_lit(0, 32'h00000000, 1'b0, "round_neg_half");
    beat(0, {D{32'h7FFF0000}}, {D{32'h00010000}});
    expect_lit(0, 32'h7FFFFFFF, 1'b1, "sat_pos");
    beat(0, {D{32'h80010000}}, {D{32'h00010000}});
    expect_lit(0, 32'h80000000, 1'b1, "sat_neg");
    beat(0, one(0, 32'h7FFFFFFF), one(0, 32'h7FFFFFFF));
    expect_lit(0, 32'h7FFFFFFF, 1'b1, "sat_product");
    beat(0, one(0, 32'h7FFF0000) | one(1, 32'h7FFF0000) | one(2, 32'h80010000) | one(3, 32'h80010000),
         {D{32'h00010000}});
    expect_lit(0, 32'h00000000, 1'b1, "sat_tree_only");

    cnt = 0; first = -1; last = -1;
    fork
      begin
        for (int i = 0; i < 12; i++) send(0, rnd_bus(1 << 20), rnd_bus(1 << 18));
        drive(0, 1'b0, '0, '0);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (ov0) begin
            cnt++;
            if (first < 0) first = k;
            last = k;
          end
        end
      end
    join
    tick();
    chk("stream_count", cnt, 12);
    chk("stream_no_bubbles", last - first + 1, 12);

    fork
      begin
        for (int i = 0; i < 25; i++) send(0, rnd_bus(1 << 20), rnd_bus(1 << 18));
        drive(0, 1'b0, '0, '0);
      end
      begin
        repeat (6) tick();
        or0 = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("bp_out_valid_held", ov0, 1);
        chk("bp_in_ready_low", ir0, 0);
        tick();
        or0 = 1'b1;
      end
    join
    repeat (15) tick();

    for (int i = 0; i < 4; i++) send(0, {D{32'h00010000}}, {D{32'h00008000}});
    drive(0, 1'b0, '0, '0);
    or0 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = ov0;
    end
    chk("pre_reset_out_valid", got, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midflight_reset_valid", ov0, 0);
    chk("midflight_reset_data", od0, 0);
    chk("midflight_reset_ready", ir0, 1);
    tick();
    or0 = 1'b1;
    beat(0, {D{32'h00010000}}, {D{32'h00008000}});
    expect_lit(0, 32'h00040000, 1'b0, "post_reset_beat");

    for (int k = 0; k < 8; k++) begin
      beat(1, one(k, 32'h00010000), one(k, 32'h00010000));
      repeat ($urandom_range(0, 3)) tick();
    end
    expect_lit(1, 32'h00080000, 1'b0, "acc8_sum");
    for (int k = 0; k < 8; k++) begin
      beat(1, one(0, 32'h00008000), one(0, 32'h00010000));
      repeat ($urandom_range(0, 3)) tick();
    end
    expect_lit(1, 32'h00040000, 1'b0, "acc8_restart");
    for (int k = 0; k < 8; k++) send(1, one(0, 32'h40000000), one(0, 32'h00010000));
    drive(1, 1'b0, '0, '0);
    expect_lit(1, 32'h7FFFFFFF, 1'b1, "acc8_final_clamp");
    for (int k = 0; k < 8; k++) send(1, one(k, 32'h00010000), one(k, 32'h00010000));
    drive(1, 1'b0, '0, '0);
    expect_lit(1, 32'h00080000, 1'b0, "acc8_sat_cleared");

    repeat (20) tick();
    chk("dut0_drained", q0.size(), 0);
    chk("dut1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
